sipo_collector: RTL and testbench
=================================

Name: sipo_collector

Overview:
- Serial-in parallel-out stage placed directly downstream of the piso serializer. Consumes its serial_o/valid_o stream.
- Reassembles WIDTH-bit words and buffers them in a small output FIFO. Presents them to the consumer with a valid/ready handshake.
- Detects broken frames (inter-bit gap timeout) and lost words (buffer overflow).

Parameters:
- WIDTH, 4, bits per word; matches the piso parallel width.
- LSB_FIRST, 1, 1: first received bit lands in bit 0; 0: first bit lands in bit WIDTH-1.
- DEPTH, 2, output FIFO entries; power of two, at least 2.
- TIMEOUT, 4, consecutive idle cycles inside a partial word before the partial word is discarded.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- serial_i  input  1  serial data bit; sampled only when valid_i=1.
- valid_i  input  1  serial_i carries a valid bit this cycle.
- parallel_o  output  WIDTH  word at the FIFO head.
- valid_o  output  1  FIFO not empty; parallel_o is valid.
- ready_i  input  1  consumer accepts parallel_o when valid_o=1 and ready_i=1.
- overflow_o  output  1  sticky; a completed word was dropped because the FIFO was full.
- frame_err_o  output  1  one-cycle pulse; a partial word was discarded on timeout.

Behaviour:
- Reset (synchronous, reset=1 at an edge):
  - bit_cnt=0, shift register=0, idle counter=0, FIFO emptied.
  - valid_o=0, parallel_o=0, overflow_o=0, frame_err_o=0.
  - Reset wins over every simultaneous event, including an in-flight partial word and a pop.
- State machine (sipo_pkg::state_t):
  - IDLE: bit_cnt==0, waiting for the first bit.
  - COLLECT: 1 ≤ bit_cnt ≤ WIDTH-1.
- Transitions:
  - IDLE, valid_i=1: capture bit, bit_cnt=1, go to COLLECT. With WIDTH==1, push immediately and stay in IDLE.
  - COLLECT, valid_i=1, bit_cnt<WIDTH-1: capture bit, bit_cnt+1, idle counter cleared.
  - COLLECT, valid_i=1, bit_cnt==WIDTH-1: the completed word (including this bit) is pushed at this same edge; bit_cnt=0; go to IDLE.
  - COLLECT, valid_i=0: idle counter +1. When it reaches TIMEOUT, discard the partial word, bit_cnt=0, pulse frame_err_o for exactly one cycle (registered, the cycle after the edge), go to IDLE.
- Bit placement:
  - LSB_FIRST=1: bit k of the frame goes to word[k].
  - LSB_FIRST=0: bit k goes to word[WIDTH-1-k].
- Latency: last bit sampled at edge N gives valid_o=1 with the word on parallel_o after edge N, when the FIFO was empty.
- FIFO:
  - First-word-fall-through; parallel_o driven from the head entry. parallel_o holds the last popped value when empty; it is meaningless when valid_o=0.
  - Pop when valid_o & ready_i.
  - Push and pop at the same edge are both performed; occupancy unchanged.
  - Full with simultaneous pop: push accepted, no overflow.
  - Full without pop: completed word dropped, overflow_o set and held until reset; FIFO contents intact.
  - Empty with ready_i=1: no pop, no state change.
  - Pointers wrap modulo DEPTH; occupancy count is $clog2(DEPTH)+1 bits wide.
- valid_i while in IDLE after a timeout starts a fresh word normally.

Decomposition:
- sipo_pkg holds:
  - typedef enum logic {IDLE, COLLECT} state_t;
  - localparam helpers for counter widths: CNT_W=$clog2(WIDTH+1) and TO_W=$clog2(TIMEOUT+1).
- One sub-module: sipo_out_fifo.
  - Parameters: WIDTH, DEPTH.
  - Ports: clk, reset, push, push_data, pop, head_data, empty, full.
- sipo_collector contains the shift/count FSM, timeout counter and error flags, and instantiates sipo_out_fifo.

Test Plan:
- Basic word: with reset released, LSB_FIRST=1 and ready_i=1, drive valid_i=1 for 4 cycles with bits 1,0,1,1 → valid_o=1 for one cycle after the 4th edge, parallel_o=4'hD, no flags.
- Back-to-back words: bits for 0xA then 0x5 contiguously with ready_i=1 → valid_o pulses twice, 4 cycles apart, parallel_o=4'hA then 4'h5.
- Overflow: ready_i=0, send 0x1, 0x2, 0x3 → overflow_o=1 after the third word's last edge. Then raise ready_i → pops 0x1, 0x2, then valid_o=0. overflow_o stays 1.
- Full plus simultaneous pop: FIFO full with 0x1 and 0x2; ready_i=1 on the edge completing 0x3 → no overflow; output sequence is 0x1, 0x2, 0x3.
- Timeout: 2 bits (1,1), then valid_i=0 for 4 cycles → frame_err_o one-cycle pulse, no push. The next 4 bits 0,1,1,0 yield parallel_o=4'h6.
- Reset mid-word and LSB_FIRST=0:
  - 2 bits, then reset=1 for one cycle → all outputs 0, FIFO empty.
  - With LSB_FIRST=0, bits 1,0,0,0 → parallel_o=4'h8.

Source files
------------

// File: rtl/sipo_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : sipo_pkg                                                   |
// | Brief    : Shared types and width helpers for the SIPO collector.     |
// | Revision : 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
package sipo_pkg;

  // IDLE: no bits of the current word received yet.
  // COLLECT: a partial word of 1..WIDTH-1 bits is in flight.
  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    COLLECT = 1'b1
  } state_t;

  // Bit counter must be able to hold the value WIDTH.
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

  // Idle counter must be able to hold the value TIMEOUT.
  function automatic int to_width(input int timeout);
    return $clog2(timeout + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/sipo_out_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : sipo_out_fifo                                              |
// | Brief    : First-word-fall-through output buffer for assembled words. |
// |            A push into a full buffer is accepted only when a pop      |
// |            happens at the same edge; otherwise it is ignored.         |
// | Revision : 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module sipo_out_fifo #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic             empty,
  output logic             full
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [PTR_W:0]   count_q;
  logic [WIDTH-1:0] last_q;
  logic             do_pop;
  logic             do_push;

  assign empty   = (count_q == '0);
  assign full    = (count_q == (PTR_W + 1)'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // Once drained, keep showing the most recently popped word.
  assign head_data = empty ? last_q : mem_q[rd_ptr_q];

  // Storage array: written on accepted pushes only, no reset needed.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

  // Pointers, occupancy and the last-popped holding register.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      last_q   <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      end
      if (do_pop) begin
        last_q   <= mem_q[rd_ptr_q];
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      if (do_push && !do_pop) begin
        count_q <= count_q + (PTR_W + 1)'(1);
      end else if (do_pop && !do_push) begin
        count_q <= count_q - (PTR_W + 1)'(1);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/sipo_collector.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : sipo_collector                                             |
// | Brief    : Reassembles a serial bit stream into WIDTH-bit words,      |
// |            buffers them, and flags frame timeouts and overflows.      |
// | Revision : 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module sipo_collector
  import sipo_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter int LSB_FIRST = 1,
  parameter int DEPTH     = 2,
  parameter int TIMEOUT   = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             serial_i,
  input  logic             valid_i,
  output logic [WIDTH-1:0] parallel_o,
  output logic             valid_o,
  input  logic             ready_i,
  output logic             overflow_o,
  output logic             frame_err_o
);

  localparam int CNT_W = cnt_width(WIDTH);
  localparam int TO_W  = to_width(TIMEOUT);

  state_t           state_q;
  logic [CNT_W-1:0] bit_cnt_q;
  logic [WIDTH-1:0] shift_q;
  logic [TO_W-1:0]  idle_q;
  logic             frame_err_q;
  logic             overflow_q;

  logic [CNT_W-1:0] pos_d;
  logic [WIDTH-1:0] word_d;
  logic             last_bit;
  logic             push;
  logic             pop;
  logic             fifo_empty;
  logic             fifo_full;

  // Build the word including the bit arriving this cycle; a new word
  // starts from zero so stale bits of a discarded frame never leak in.
  always_comb begin
    pos_d  = (LSB_FIRST != 0) ? bit_cnt_q : (CNT_W'(WIDTH - 1) - bit_cnt_q);
    word_d = (state_q == IDLE) ? '0 : shift_q;
    for (int k = 0; k < WIDTH; k++) begin
      if (CNT_W'(k) == pos_d) begin
        word_d[k] = serial_i;
      end
    end
  end

  assign last_bit = (bit_cnt_q == CNT_W'(WIDTH - 1));
  assign push     = valid_i && last_bit;
  assign pop      = !fifo_empty && ready_i;

  // Bit-collection FSM with inter-bit timeout and sticky overflow.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      idle_q      <= '0;
      frame_err_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      frame_err_q <= 1'b0;
      if (push && fifo_full && !pop) begin
        overflow_q <= 1'b1;
      end
      case (state_q)
        IDLE: begin
          if (valid_i) begin
            idle_q <= '0;
            if (!last_bit) begin
              shift_q   <= word_d;
              bit_cnt_q <= CNT_W'(1);
              state_q   <= COLLECT;
            end
          end
        end
        COLLECT: begin
          if (valid_i) begin
            idle_q <= '0;
            if (last_bit) begin
              bit_cnt_q <= '0;
              shift_q   <= '0;
              state_q   <= IDLE;
            end else begin
              shift_q   <= word_d;
              bit_cnt_q <= bit_cnt_q + CNT_W'(1);
            end
          end else if (idle_q == TO_W'(TIMEOUT - 1)) begin
            idle_q      <= '0;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            frame_err_q <= 1'b1;
            state_q     <= IDLE;
          end else begin
            idle_q <= idle_q + TO_W'(1);
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  sipo_out_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (word_d),
    .pop       (pop),
    .head_data (parallel_o),
    .empty     (fifo_empty),
    .full      (fifo_full)
  );

  assign valid_o     = !fifo_empty;
  assign overflow_o  = overflow_q;
  assign frame_err_o = frame_err_q;

endmodule
`default_nettype wire

// File: tb/tb_sipo_collector.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_sipo_collector                                          |
// | Brief    : Directed bench for sipo_collector; an LSB-first and an     |
// |            MSB-first instance receive the same serial stream.         |
// | Revision : 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module tb_sipo_collector;

  logic       clk = 1'b0;
  logic       reset;
  logic       serial_i;
  logic       valid_i;
  logic       ready_i;
  logic [3:0] par_a, par_b;
  logic       val_a, val_b, ovf_a, ovf_b, fer_a, fer_b;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  sipo_collector #(.WIDTH(4), .LSB_FIRST(1), .DEPTH(2), .TIMEOUT(4)) u_dut_a (
    .clk(clk), .reset(reset), .serial_i(serial_i), .valid_i(valid_i),
    .parallel_o(par_a), .valid_o(val_a), .ready_i(ready_i),
    .overflow_o(ovf_a), .frame_err_o(fer_a)
  );

  sipo_collector #(.WIDTH(4), .LSB_FIRST(0), .DEPTH(2), .TIMEOUT(4)) u_dut_b (
    .clk(clk), .reset(reset), .serial_i(serial_i), .valid_i(valid_i),
    .parallel_o(par_b), .valid_o(val_b), .ready_i(ready_i),
    .overflow_o(ovf_b), .frame_err_o(fer_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock; outputs are then examined 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    valid_i  = 1'b1;
    serial_i = b;
    tick();
    valid_i  = 1'b0;
    serial_i = 1'b0;
  endtask

  // Sends four bits, LSB of 'w' first; outputs checked by the caller.
  task automatic send_word(input logic [3:0] w);
    for (int i = 0; i < 4; i++) begin
      send_bit(w[i]);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; serial_i = 1'b0; valid_i = 1'b0; ready_i = 1'b0;
    tick();
    reset = 1'b0;
    chk("rst_valid", val_a, 0);
    chk("rst_par",   par_a, 0);
    chk("rst_ovf",   ovf_a, 0);
    chk("rst_ferr",  fer_a, 0);

    // Basic word 1,0,1,1 -> A=D, B=B
    ready_i = 1'b1;
    send_bit(1); send_bit(0); send_bit(1);
    chk("basic_not_yet", val_a, 0);
    send_bit(1);
    chk("basic_valid", val_a, 1);
    chk("basic_par",   par_a, 4'hD);
    chk("basic_msb",   par_b, 4'hB);
    chk("basic_flags", {ovf_a, fer_a}, 0);
    tick();
    chk("basic_popped", val_a, 0);

    // Back-to-back A then 5
    send_word(4'hA);
    chk("b2b_v1", val_a, 1);
    chk("b2b_p1", par_a, 4'hA);
    send_bit(1);
    chk("b2b_gap", val_a, 0);
    send_bit(0); send_bit(1); send_bit(0);
    chk("b2b_v2", val_a, 1);
    chk("b2b_p2", par_a, 4'h5);
    tick();
    chk("b2b_done", val_a, 0);

    // Overflow with consumer stalled
    ready_i = 1'b0;
    send_word(4'h1);
    chk("ovf_head1", par_a, 4'h1);
    send_word(4'h2);
    chk("ovf_none_yet", ovf_a, 0);
    send_word(4'h3);
    chk("ovf_set", ovf_a, 1);
    chk("ovf_head_kept", par_a, 4'h1);
    ready_i = 1'b1;
    tick();
    chk("ovf_pop2_v", val_a, 1);
    chk("ovf_pop2_p", par_a, 4'h2);
    tick();
    chk("ovf_drained", val_a, 0);
    chk("ovf_sticky", ovf_a, 1);
    ready_i = 1'b0;
    do_reset();
    chk("ovf_cleared", ovf_a, 0);

    // Full with simultaneous pop on the completing edge
    send_word(4'h1);
    send_word(4'h2);
    send_bit(1); send_bit(1); send_bit(0);
    ready_i = 1'b1;
    send_bit(0);
    chk("fullpop_ovf", ovf_a, 0);
    chk("fullpop_p2",  par_a, 4'h2);
    tick();
    chk("fullpop_p3v", val_a, 1);
    chk("fullpop_p3",  par_a, 4'h3);
    tick();
    chk("fullpop_empty", val_a, 0);

    // Timeout after two bits
    send_bit(1); send_bit(1);
    tick(); tick(); tick();
    chk("to_not_yet", fer_a, 0);
    tick();
    chk("to_pulse", fer_a, 1);
    chk("to_nopush", val_a, 0);
    tick();
    chk("to_one_cycle", fer_a, 0);
    send_bit(0); send_bit(1); send_bit(1);
    chk("to_fresh_wait", val_a, 0);
    send_bit(0);
    chk("to_fresh_v", val_a, 1);
    chk("to_fresh_p", par_a, 4'h6);
    tick();

    // Reset mid-word, with a bit arriving on the reset edge
    send_bit(1); send_bit(1);
    ready_i = 1'b0;
    send_word(4'h9);
    reset = 1'b1; valid_i = 1'b1; serial_i = 1'b1; ready_i = 1'b1;
    tick();
    reset = 1'b0; valid_i = 1'b0; serial_i = 1'b0;
    chk("rstmid_out", {val_a, par_a, ovf_a, fer_a}, 0);
    chk("rstmid_out_b", {val_b, par_b, ovf_b, fer_b}, 0);
    send_bit(1); send_bit(0); send_bit(0);
    chk("rstmid_cnt", val_b, 0);
    send_bit(0);
    chk("msb_valid", val_b, 1);
    chk("msb_par",   par_b, 4'h8);
    chk("lsb_par",   par_a, 4'h1);
    tick();
    chk("final_empty", val_b, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
